// File: rtl/vga_timing_pkg.sv
// Shared run-state encoding, default VGA 640x480 timing and helpers for
// deriving line/frame totals and sync windows from the porch parameters.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } run_state_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_DIV      = 2;
  localparam int DEF_SYNC_POL = 0;

  localparam int CNT_W   = 10;
  localparam int FRAME_W = 8;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_first(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_last(input int active, input int fp, input int sync);
    return active + fp + sync - 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                     input logic [CNT_W-1:0] first,
                                     input logic [CNT_W-1:0] last);
    return (pos >= first) && (pos <= last);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Clock divider producing a one-cycle pixel boundary pulse every DIV cycles;
// held at zero while clr is asserted so the first boundary is DIV cycles out.
module pixel_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV_W = cnt_width(DIV);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: run/stop FSM, pixel counters and registered decode of
// sync, blanking and line/frame strobes, all aligned with the presented pixel.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int DIV      = DEF_DIV,
  parameter int SYNC_POL = DEF_SYNC_POL
) (
  input  logic               CLKt,
  input  logic               RST,
  input  logic               EN,
  output logic               PTICK,
  output logic [CNT_W-1:0]   HCOUNT,
  output logic [CNT_W-1:0]   VCOUNT,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic               VIDON,
  output logic               LINE_START,
  output logic               FRAME_START,
  output logic [FRAME_W-1:0] FRAME_CNT,
  output logic               RUNNING
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(sync_first(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(sync_last(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(sync_first(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(sync_last(V_ACTIVE, V_FP, V_SYNC));
  localparam logic             SYNC_ON  = (SYNC_POL != 0);

  run_state_t state_q, state_d;
  logic       tick, div_clr, frame_end, start;

  logic [CNT_W-1:0]   hcount_p0, vcount_p0;
  logic               vld_p0, run_p0, hsync_p0, vsync_p0, vidon_p0, line_p0, frame_p0;
  logic [CNT_W-1:0]   hcount_p1, vcount_p1;
  logic               vld_p1, run_p1, hsync_p1, vsync_p1, vidon_p1, line_p1, frame_p1;
  logic [FRAME_W-1:0] frame_cnt_p1;

  assign div_clr = (state_q == IDLE);

  pixel_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (CLKt),
    .rst  (RST),
    .clr  (div_clr),
    .tick (tick)
  );

  assign frame_end = (hcount_p1 == H_LAST) && (vcount_p1 == V_LAST);

  // A pending stop is cancelled by EN before it can retire at the frame end.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (EN) state_d = RUN;
      RUN:       if (!EN) state_d = STOP_PEND;
      STOP_PEND: begin
        if (EN)                     state_d = RUN;
        else if (tick && frame_end) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // Stage p0: next presented pixel and its decode
  always_comb begin
    run_p0    = (state_d != IDLE);
    start     = (state_q == IDLE) && run_p0;
    hcount_p0 = hcount_p1;
    vcount_p0 = vcount_p1;
    vld_p0    = 1'b0;
    if (!run_p0) begin
      hcount_p0 = '0;
      vcount_p0 = '0;
    end else if (start) begin
      hcount_p0 = '0;
      vcount_p0 = '0;
      vld_p0    = 1'b1;
    end else if (tick) begin
      vld_p0 = 1'b1;
      if (hcount_p1 == H_LAST) begin
        hcount_p0 = '0;
        vcount_p0 = (vcount_p1 == V_LAST) ? '0 : vcount_p1 + CNT_W'(1);
      end else begin
        hcount_p0 = hcount_p1 + CNT_W'(1);
      end
    end
    hsync_p0 = (run_p0 && in_window(hcount_p0, HS_FIRST, HS_LAST)) ? SYNC_ON : ~SYNC_ON;
    vsync_p0 = (run_p0 && in_window(vcount_p0, VS_FIRST, VS_LAST)) ? SYNC_ON : ~SYNC_ON;
    vidon_p0 = run_p0 && (hcount_p0 < H_VIS) && (vcount_p0 < V_VIS);
    line_p0  = vld_p0 && (hcount_p0 == '0);
    frame_p0 = line_p0 && (vcount_p0 == '0);
  end

  // Stage p1: registered outputs
  always_ff @(posedge CLKt) begin
    if (RST) begin
      state_q      <= IDLE;
      hcount_p1    <= '0;
      vcount_p1    <= '0;
      vld_p1       <= 1'b0;
      run_p1       <= 1'b0;
      hsync_p1     <= ~SYNC_ON;
      vsync_p1     <= ~SYNC_ON;
      vidon_p1     <= 1'b0;
      line_p1      <= 1'b0;
      frame_p1     <= 1'b0;
      frame_cnt_p1 <= '0;
    end else begin
      state_q   <= state_d;
      hcount_p1 <= hcount_p0;
      vcount_p1 <= vcount_p0;
      vld_p1    <= vld_p0;
      run_p1    <= run_p0;
      hsync_p1  <= hsync_p0;
      vsync_p1  <= vsync_p0;
      vidon_p1  <= vidon_p0;
      line_p1   <= line_p0;
      frame_p1  <= frame_p0;
      if (frame_p1) frame_cnt_p1 <= frame_cnt_p1 + FRAME_W'(1);
    end
  end

  assign PTICK       = vld_p1;
  assign HCOUNT      = hcount_p1;
  assign VCOUNT      = vcount_p1;
  assign HSYNC       = hsync_p1;
  assign VSYNC       = vsync_p1;
  assign VIDON       = vidon_p1;
  assign LINE_START  = line_p1;
  assign FRAME_START = frame_p1;
  assign FRAME_CNT   = frame_cnt_p1;
  assign RUNNING     = run_p1;

endmodule
